// File: rtl/ic_queue.sv
// Fetch-to-decode instruction queue: circular buffer with flush/branch kill.
// Optional IC_QUEUE_BYPASS_EN macro enables zero-latency pass-through when empty.
module ic_queue #(
    parameter int unsigned WIDTH = 65,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     br_e,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             kill;
    logic             bypass;
    logic             push;
    logic             pop;

    assign kill = flush | br_e;

`ifdef IC_QUEUE_BYPASS_EN
    // Empty queue hands the fetched bundle straight to decode without storing it.
    assign bypass = empty & in_valid & out_ready & ~kill;
`else
    assign bypass = 1'b0;
`endif

    assign empty    = (count == CW'(0));
    assign full     = (count == CW'(DEPTH));
    assign in_ready = ~full;
    assign push     = in_valid & ~full & ~kill & ~bypass;
    assign pop      = ~empty & out_ready & ~kill;

    assign out_valid = ~empty | bypass;

    // Bubble is all-zero so decode sees a clean nop payload when nothing is queued.
    always_comb begin
        out_data = '0;
        if (!empty) begin
            out_data = mem[rd_ptr];
        end else if (bypass) begin
            out_data = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (kill) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_ic_queue.sv
// Self-checking bench for ic_queue against a queue-based reference model.
module tb_ic_queue;

    localparam int unsigned WIDTH = 65;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;
`ifdef IC_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             flush;
    logic             br_e;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] model_q [$];

    ic_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .br_e     (br_e),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .count    (count),
        .empty    (empty),
        .full     (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit exp_byp();
        return BYP && (model_q.size() == 0) && in_valid && out_ready && !flush && !br_e;
    endfunction

    function automatic logic [WIDTH-1:0] exp_data();
        if (model_q.size() > 0) return model_q[0];
        if (exp_byp()) return in_data;
        return '0;
    endfunction

    function automatic logic [WIDTH-1:0] rnd_data();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[WIDTH-1:0];
    endfunction

    task automatic set_in(input logic fl, input logic br, input logic iv,
                          input logic [WIDTH-1:0] d, input logic ordy);
        flush     = fl;
        br_e      = br;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        #1;
    endtask

    // Advance one edge and apply the queue semantics to the model.
    task automatic tick();
        bit byp;
        bit pu;
        bit po;
        @(posedge clk);
        if (rst || flush || br_e) begin
            model_q.delete();
        end else begin
            byp = exp_byp();
            pu  = in_valid && (model_q.size() < DEPTH) && !byp;
            po  = (model_q.size() > 0) && out_ready;
            if (po) void'(model_q.pop_front());
            if (pu) model_q.push_back(in_data);
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(0, 0, 0, '0, 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (count !== CW'(0) || empty !== 1'b1 || full !== 1'b0 || out_valid !== 1'b0 ||
            out_data !== '0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset got count=%0d empty=%b full=%b ov=%b od=%h ir=%b req count=0 empty=1 full=0 ov=0 od=0 ir=1",
                     count, empty, full, out_valid, out_data, in_ready);
        end
    endtask

    task automatic test_order();
        logic [WIDTH-1:0] v [3];
        v[0] = 65'h1_0000_00A0;
        v[1] = 65'h1_0000_00A4;
        v[2] = 65'h1_0000_00A8;
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 1, v[i], 0);
            tick();
        end
        set_in(0, 0, 0, '0, 0);
        checks++;
        if (count !== CW'(3) || out_data !== v[0] || full !== 1'b0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL order_fill got count=%0d od=%h full=%b req count=3 od=%h full=0",
                     count, out_data, full, v[0]);
        end
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 0, '0, 1);
            checks++;
            if (out_data !== v[i] || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL order_pop%0d got %h req %h", i, out_data, v[i]);
            end
            tick();
        end
        set_in(0, 0, 0, '0, 0);
        checks++;
        if (empty !== 1'b1 || out_data !== '0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL order_empty got empty=%b od=%h ov=%b req 1 0 0", empty, out_data, out_valid);
        end
    endtask

    task automatic test_full();
        logic [WIDTH-1:0] v [5];
        for (int i = 0; i < 5; i++) v[i] = rnd_data();
        for (int i = 0; i < 4; i++) begin
            set_in(0, 0, 1, v[i], 0);
            tick();
        end
        set_in(0, 0, 1, v[4], 0);
        checks++;
        if (full !== 1'b1 || in_ready !== 1'b0 || count !== CW'(DEPTH)) begin
            failures++;
            $display("FAIL full_flag got full=%b ir=%b count=%0d req 1 0 %0d", full, in_ready, count, DEPTH);
        end
        tick();
        checks++;
        if (count !== CW'(DEPTH) || out_data !== v[0]) begin
            failures++;
            $display("FAIL full_hold got count=%0d od=%h req %0d %h", count, out_data, DEPTH, v[0]);
        end
        set_in(0, 0, 1, v[4], 1);
        tick();
        checks++;
        if (count !== CW'(DEPTH - 1) || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL full_pop got count=%0d ir=%b req %0d 1", count, in_ready, DEPTH - 1);
        end
        set_in(0, 0, 1, v[4], 0);
        tick();
        checks++;
        if (count !== CW'(DEPTH)) begin
            failures++;
            $display("FAIL full_accept got count=%0d req %0d", count, DEPTH);
        end
        for (int i = 1; i < 5; i++) begin
            set_in(0, 0, 0, '0, 1);
            checks++;
            if (out_data !== v[i]) begin
                failures++;
                $display("FAIL full_drain%0d got %h req %h", i, out_data, v[i]);
            end
            tick();
        end
    endtask

    task automatic test_kill();
        logic [WIDTH-1:0] fresh;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 3; i++) begin
                set_in(0, 0, 1, rnd_data(), 0);
                tick();
            end
            set_in(k != 1, k != 0, 1, rnd_data(), 1);
            tick();
            set_in(0, 0, 0, '0, 0);
            checks++;
            if (count !== CW'(0) || out_valid !== 1'b0 || out_data !== '0 || empty !== 1'b1) begin
                failures++;
                $display("FAIL kill%0d got count=%0d ov=%b od=%h req 0 0 0", k, count, out_valid, out_data);
            end
            fresh = rnd_data();
            set_in(0, 0, 1, fresh, 0);
            tick();
            set_in(0, 0, 0, '0, 1);
            checks++;
            if (out_data !== fresh || count !== CW'(1)) begin
                failures++;
                $display("FAIL kill_after%0d got od=%h count=%0d req %h 1", k, out_data, count, fresh);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 2; i++) begin
            set_in(0, 0, 1, rnd_data(), 0);
            tick();
        end
        for (int i = 0; i < 2 * DEPTH + 1; i++) begin
            set_in(0, 0, 1, rnd_data(), 1);
            checks++;
            if (count !== CW'(2) || out_data !== exp_data()) begin
                failures++;
                $display("FAIL b2b%0d got count=%0d od=%h req 2 %h", i, count, out_data, exp_data());
            end
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            set_in(0, 0, 0, '0, 1);
            checks++;
            if (out_data !== exp_data()) begin
                failures++;
                $display("FAIL b2b_drain%0d got %h req %h", i, out_data, exp_data());
            end
            tick();
        end
    endtask

    task automatic test_bypass();
        logic [WIDTH-1:0] v;
        v = 65'h0_BFC0_0000;
        set_in(0, 0, 1, v, 1);
        checks++;
        if (out_valid !== BYP || out_data !== (BYP ? v : '0)) begin
            failures++;
            $display("FAIL bypass_same got ov=%b od=%h req ov=%b", out_valid, out_data, BYP);
        end
        tick();
        set_in(0, 0, 0, '0, 0);
        checks++;
        if (count !== (BYP ? CW'(0) : CW'(1)) || out_data !== (BYP ? '0 : v)) begin
            failures++;
            $display("FAIL bypass_next got count=%0d od=%h req count=%0d", count, out_data, BYP ? 0 : 1);
        end
        set_in(0, 0, 0, '0, 1);
        tick();
    endtask

    task automatic test_rst_mid();
        for (int i = 0; i < 2; i++) begin
            set_in(0, 0, 1, rnd_data(), 0);
            tick();
        end
        rst = 1'b1;
        set_in(0, 0, 1, rnd_data(), 1);
        tick();
        rst = 1'b0;
        set_in(0, 0, 0, '0, 0);
        checks++;
        if (count !== CW'(0) || empty !== 1'b1 || full !== 1'b0 || out_valid !== 1'b0 ||
            out_data !== '0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid got count=%0d empty=%b full=%b ov=%b od=%h ir=%b",
                     count, empty, full, out_valid, out_data, in_ready);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 99) < 2);
            set_in($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 4,
                   $urandom_range(0, 99) < 70, rnd_data(), $urandom_range(0, 99) < 50);
            if (!rst) begin
                checks++;
                if (count !== CW'(model_q.size()) || out_valid !== (model_q.size() > 0 || exp_byp()) ||
                    out_data !== exp_data() || full !== (model_q.size() == DEPTH) ||
                    empty !== (model_q.size() == 0) || in_ready !== (model_q.size() < DEPTH)) begin
                    failures++;
                    $display("FAIL random cyc=%0d got count=%0d ov=%b od=%h full=%b empty=%b ir=%b req count=%0d od=%h",
                             c, count, out_valid, out_data, full, empty, in_ready, model_q.size(), exp_data());
                end
            end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        br_e = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        test_reset();
        test_order();
        test_full();
        test_kill();
        test_back_to_back();
        test_bypass();
        test_rst_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ic_queue.md
IC_QUEUE -- requirements
Module: ic_queue

Interface
REQ-001 Parameter WIDTH, default 65, payload width in bits (excepttype 32 + ce 1 + pc 32).
REQ-002 Parameter DEPTH, default 4, number of entries; power of two, DEPTH >= 2.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 flush  input  1  exception flush; discards all entries.
REQ-006 br_e  input  1  branch-taken kill; discards all entries, same effect as flush.
REQ-007 in_valid  input  1  producer (fetch side) presents in_data.
REQ-008 in_data  input  WIDTH  fetched instruction bundle.
REQ-009 in_ready  output  1  queue accepts a push this cycle.
REQ-010 out_valid  output  1  head entry available to decode.
REQ-011 out_data  output  WIDTH  head entry payload.
REQ-012 out_ready  input  1  decode consumes head this cycle (driven from stall: not stalled).
REQ-013 count  output  clog2(DEPTH)+1  number of valid entries.
REQ-014 empty  output  1  count == 0.
REQ-015 full  output  1  count == DEPTH.

Function
REQ-016 Storage SHALL be a circular buffer of DEPTH x WIDTH with read/write pointers of clog2(DEPTH) bits, wrapping DEPTH-1 -> 0.
REQ-017 in_ready SHALL equal !full (no same-cycle pop credit when full).
REQ-018 Push SHALL occur when in_valid && in_ready && !flush && !br_e: write at wr_ptr, wr_ptr+1.
REQ-019 Pop SHALL occur when out_valid && out_ready && !flush && !br_e: rd_ptr+1.
REQ-020 Simultaneous push and pop SHALL leave count unchanged; push alone +1; pop alone -1.
REQ-021 out_valid SHALL equal !empty; out_data SHALL be mem[rd_ptr] when !empty, all-zero otherwise (bubble).
REQ-022 Push-to-out latency SHALL be 1 cycle: entry pushed at edge N is visible on out_data after edge N when queue was empty.
REQ-023 flush or br_e SHALL, at the next edge, zero both pointers and count; any concurrent push or pop is ignored; out_valid low and out_data zero the following cycle.
REQ-024 flush and br_e asserted together SHALL behave identically to either alone.
REQ-025 in_valid while full SHALL not modify storage; producer holds data until in_ready.
REQ-026 Pop while empty SHALL have no effect (no pointer movement, no underflow).
REQ-027 Entries SHALL leave in strict push order; no reorder, no duplication.

Reset
REQ-028 On rst at a rising edge: pointers 0, count 0, empty 1, full 0, out_valid 0, out_data 0, in_ready 1.
REQ-029 rst SHALL take priority over flush, br_e, push and pop; storage contents need not be cleared.
REQ-030 rst asserted mid-operation SHALL discard all entries identically to REQ-028.

Configuration
REQ-031 Macro IC_QUEUE_BYPASS_EN: when defined, if empty && in_valid && out_ready && !flush && !br_e, in_data SHALL drive out_data combinationally with out_valid 1, and the entry SHALL NOT be stored (zero-latency pass-through, count stays 0).
REQ-032 Without IC_QUEUE_BYPASS_EN: out_valid SHALL depend only on registered state; minimum latency 1 cycle per REQ-022.

Verification
REQ-033 Reset then push 0x...A0,0x...A4,0x...A8 with out_ready=0 -> count 3, out_data=0x...A0, full 0; then out_ready=1 for 3 cycles -> A0,A4,A8 in order, then empty 1, out_data 0.
REQ-034 DEPTH=4, push 5 values with out_ready=0 -> full 1 after 4th, in_ready 0, 5th held; pop once -> 5th accepted next cycle, count 4.
REQ-035 Fill to 3, assert br_e with in_valid=1 same cycle -> next cycle count 0, out_valid 0, pushed value absent.
REQ-036 Steady push+pop every cycle for 2*DEPTH+1 cycles -> count constant, pointers wrap, output order matches input.
REQ-037 With IC_QUEUE_BYPASS_EN, empty queue, in_valid=1 data 0xBFC00000, out_ready=1 -> out_data 0xBFC00000 same cycle, count stays 0; without macro -> appears one cycle later.
REQ-038 rst asserted with count 2 and flush=0 -> next cycle all outputs per REQ-028.
